// File: rtl/lfsr_stepper.sv
// lfsr_stepper
//   Fibonacci LFSR with seed load, free-run stepping and a counted
//   "advance N steps" command with busy/done handshake. Flags the step that
//   returns the state to the reference seed (wrap) and substitutes SEED for
//   an all-zero load value (seed_err).
//
//   Optional build macro: LFSR_PERIOD_CNT_EN
//     When defined, adds output period_out, which holds the number of steps
//     between the two most recent returns to the reference seed.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   en         in   free-run step enable (honoured in IDLE and DONE)
//   load       in   load seed_in (zero substituted by SEED)
//   seed_in    in   [WIDTH-1:0] seed value
//   start      in   begin counted run (accepted in IDLE only)
//   n_steps    in   [CNT_W-1:0] step count, sampled with start
//   data_out   out  [WIDTH-1:0] current LFSR state
//   busy       out  counted run in progress
//   done       out  one-cycle pulse, counted run complete
//   wrap       out  one-cycle pulse, previous step landed on the reference seed
//   seed_err   out  one-cycle pulse, zero seed was replaced by SEED
//   period_out out  [WIDTH-1:0] measured period (LFSR_PERIOD_CNT_EN only)
//
// FSM states
//   state | meaning
//   IDLE  | waiting; en steps, start accepted
//   RUN   | counted run, one step per cycle until remaining reaches zero
//   DONE  | single-cycle completion pulse; en steps, start ignored
module lfsr_stepper #(
  parameter int               WIDTH = 4,
  parameter logic [WIDTH-1:0] TAPS  = 4'hC,
  parameter logic [WIDTH-1:0] SEED  = {{(WIDTH-1){1'b0}}, 1'b1},
  parameter int               CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             start,
  input  logic [CNT_W-1:0] n_steps,
  output logic [WIDTH-1:0] data_out,
  output logic             busy,
  output logic             done,
  output logic             wrap,
  output logic             seed_err
`ifdef LFSR_PERIOD_CNT_EN
  ,
  output logic [WIDTH-1:0] period_out
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  fsm_t             fsm, fsm_nxt;
  logic [CNT_W-1:0] remaining, remaining_nxt;
  logic [WIDTH-1:0] ref_seed;
  logic [WIDTH-1:0] step_val;
  logic [WIDTH-1:0] load_val;
  logic             stepping;
  logic             wrap_nxt;

  assign step_val = {data_out[WIDTH-2:0], ^(data_out & TAPS)};
  assign load_val = (seed_in == '0) ? SEED : seed_in;
  // wrap compares against the seed in force before this edge; a load on the
  // same edge never steps, so there is no overlap to resolve.
  assign wrap_nxt = stepping && (step_val == ref_seed);

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm       <= IDLE;
      remaining <= '0;
    end else begin
      fsm       <= fsm_nxt;
      remaining <= remaining_nxt;
    end
  end

  always_comb begin
    fsm_nxt       = fsm;
    remaining_nxt = remaining;
    stepping      = 1'b0;
    if (load) begin
      fsm_nxt       = IDLE;
      remaining_nxt = '0;
    end else begin
      case (fsm)
        IDLE: begin
          if (start) begin
            if (n_steps == '0) begin
              fsm_nxt = DONE;
            end else begin
              fsm_nxt       = RUN;
              remaining_nxt = n_steps;
            end
          end else begin
            stepping = en;
          end
        end
        RUN: begin
          stepping      = 1'b1;
          remaining_nxt = remaining - 1'b1;
          if (remaining == CNT_W'(1)) fsm_nxt = DONE;
        end
        DONE: begin
          stepping = en;
          fsm_nxt  = IDLE;
        end
        default: fsm_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_out <= SEED;
      ref_seed <= SEED;
      busy     <= 1'b0;
      done     <= 1'b0;
      wrap     <= 1'b0;
      seed_err <= 1'b0;
    end else begin
      if (load) begin
        data_out <= load_val;
        ref_seed <= load_val;
      end else if (stepping) begin
        data_out <= step_val;
      end
      busy     <= (fsm_nxt == RUN);
      done     <= (fsm_nxt == DONE);
      wrap     <= wrap_nxt;
      seed_err <= load && (seed_in == '0);
    end
  end

`ifdef LFSR_PERIOD_CNT_EN
  logic [WIDTH-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || load) begin
      cnt        <= '0;
      period_out <= '0;
    end else if (stepping) begin
      if (wrap_nxt) begin
        period_out <= cnt + 1'b1;
        cnt        <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_lfsr_stepper.sv
// tb_lfsr_stepper
//   Directed scenarios for the default 4-bit generator followed by a random
//   run checked against a sequence-index reference model. The model tracks
//   the position in the known 15-entry x^4+x+1 sequence rather than shifting
//   bits.
module tb_lfsr_stepper;

  logic        clk = 1'b0;
  logic        rst, en, load, start;
  logic [3:0]  seed_in;
  logic [15:0] n_steps;
  logic [3:0]  data_out;
  logic        busy, done, wrap, seed_err;
`ifdef LFSR_PERIOD_CNT_EN
  logic [3:0]  period_out;
`endif

  always #5 clk = ~clk;

  lfsr_stepper dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .seed_in(seed_in),
    .start(start), .n_steps(n_steps), .data_out(data_out), .busy(busy),
    .done(done), .wrap(wrap), .seed_err(seed_err)
`ifdef LFSR_PERIOD_CNT_EN
    , .period_out(period_out)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model: index into the known maximal sequence.
  logic [3:0] seq [15] = '{4'd1, 4'd2, 4'd4, 4'd9, 4'd3, 4'd6, 4'd13, 4'd10,
                           4'd5, 4'd11, 4'd7, 4'd15, 4'd14, 4'd12, 4'd8};
  int         m_idx, m_mode, m_left, m_cnt, m_per;  // mode: 0 idle, 1 run, 2 done
  logic [3:0] m_ref;
  logic       m_wrap, m_err;

  function automatic int idx_of(logic [3:0] v);
    for (int i = 0; i < 15; i++) if (seq[i] == v) return i;
    return 0;
  endfunction

  task automatic tick();
    logic       stepped;
    logic [3:0] v;
    stepped = 1'b0;
    @(posedge clk);
    m_wrap = 1'b0;
    m_err  = 1'b0;
    if (rst) begin
      m_idx = 0; m_ref = 4'd1; m_mode = 0; m_left = 0; m_cnt = 0; m_per = 0;
    end else if (load) begin
      v      = (seed_in == 4'd0) ? 4'd1 : seed_in;
      m_err  = (seed_in == 4'd0);
      m_idx  = idx_of(v);
      m_ref  = v;
      m_mode = 0;
      m_left = 0;
      m_cnt  = 0;
      m_per  = 0;
    end else if (m_mode == 0 && start) begin
      if (n_steps == 16'd0) m_mode = 2;
      else begin m_mode = 1; m_left = int'(n_steps); end
    end else if (m_mode == 1) begin
      stepped = 1'b1;
      m_left--;
      if (m_left == 0) m_mode = 2;
    end else begin
      stepped = en;
      if (m_mode == 2) m_mode = 0;
    end
    if (stepped) begin
      m_idx  = (m_idx + 1) % 15;
      m_wrap = (seq[m_idx] == m_ref);
      if (m_wrap) begin m_per = m_cnt + 1; m_cnt = 0; end
      else m_cnt++;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; load = 1'b0; start = 1'b0; seed_in = '0; n_steps = '0;
    tick(); tick();
    rst = 1'b0;
    checks++;
    if (data_out !== 4'd1 || busy !== 1'b0 || done !== 1'b0 || wrap !== 1'b0 || seed_err !== 1'b0) begin
      errors++;
      $display("FAIL reset: data=%0d busy=%b done=%b wrap=%b err=%b, want 1 0 0 0 0",
               data_out, busy, done, wrap, seed_err);
    end
  endtask

  task automatic test_free_run();
    logic [3:0] exp [15] = '{4'd2, 4'd4, 4'd9, 4'd3, 4'd6, 4'd13, 4'd10, 4'd5,
                             4'd11, 4'd7, 4'd15, 4'd14, 4'd12, 4'd8, 4'd1};
    en = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      checks++;
      if (data_out !== exp[i] || wrap !== (i == 14)) begin
        errors++;
        $display("FAIL free_run step %0d: data=%0d wrap=%b, want %0d %b",
                 i, data_out, wrap, exp[i], (i == 14));
      end
    end
    en = 1'b0;
    tick();
    checks++;
    if (wrap !== 1'b0 || data_out !== 4'd1) begin
      errors++;
      $display("FAIL free_run hold: data=%0d wrap=%b, want 1 0", data_out, wrap);
    end
  endtask

  task automatic test_counted();
    int busy_cycles;
    busy_cycles = 0;
    start = 1'b1; n_steps = 16'd5;
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || data_out !== 4'd1) begin
      errors++;
      $display("FAIL counted accept: busy=%b data=%0d, want 1 1", busy, data_out);
    end
    for (int i = 0; i < 12 && busy === 1'b1; i++) begin
      busy_cycles++;
      tick();
    end
    checks++;
    if (busy_cycles !== 5 || done !== 1'b1 || data_out !== 4'd6) begin
      errors++;
      $display("FAIL counted run: busy_cycles=%0d done=%b data=%0d, want 5 1 6",
               busy_cycles, done, data_out);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || data_out !== 4'd6) begin
      errors++;
      $display("FAIL counted after: done=%b busy=%b data=%0d, want 0 0 6", done, busy, data_out);
    end
  endtask

  task automatic test_zero_steps();
    start = 1'b1; n_steps = 16'd0;
    tick();
    start = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || data_out !== 4'd6) begin
      errors++;
      $display("FAIL zero_steps: done=%b busy=%b data=%0d, want 1 0 6", done, busy, data_out);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_steps after: done=%b busy=%b, want 0 0", done, busy);
    end
  endtask

  task automatic test_load_abort();
    load = 1'b1; seed_in = 4'd0;
    tick();
    load = 1'b0;
    checks++;
    if (data_out !== 4'd1 || seed_err !== 1'b1) begin
      errors++;
      $display("FAIL zero_seed: data=%0d seed_err=%b, want 1 1", data_out, seed_err);
    end
    tick();
    checks++;
    if (seed_err !== 1'b0) begin
      errors++;
      $display("FAIL zero_seed pulse: seed_err=%b, want 0", seed_err);
    end
    start = 1'b1; n_steps = 16'd10;
    tick();
    start = 1'b0;
    tick(); tick();
    load = 1'b1; seed_in = 4'hA;
    tick();
    load = 1'b0;
    checks++;
    if (data_out !== 4'hA || busy !== 1'b0 || done !== 1'b0 || seed_err !== 1'b0) begin
      errors++;
      $display("FAIL abort: data=%0h busy=%b done=%b err=%b, want a 0 0 0",
               data_out, busy, done, seed_err);
    end
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++;
      if (done !== 1'b0 || data_out !== 4'hA) begin
        errors++;
        $display("FAIL abort tail %0d: done=%b data=%0h, want 0 a", i, done, data_out);
      end
    end
  endtask

  task automatic test_en_during_run();
    load = 1'b1; seed_in = 4'd1;
    tick();
    load = 1'b0;
    en = 1'b1; start = 1'b1; n_steps = 16'd3;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (done !== 1'b1 || data_out !== 4'd9) begin
      errors++;
      $display("FAIL en_during_run: done=%b data=%0d, want 1 9", done, data_out);
    end
    en = 1'b0;
    tick();
  endtask

  task automatic test_random();
    rst = 1'b1; tick(); rst = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      rst     = ($urandom_range(0, 99) == 0);
      load    = ($urandom_range(0, 15) == 0);
      seed_in = 4'($urandom_range(0, 15));
      start   = ($urandom_range(0, 3) == 0);
      n_steps = 16'($urandom_range(0, 20));
      en      = 1'($urandom);
      tick();
      checks++;
      if (data_out !== seq[m_idx] || busy !== (m_mode == 1) || done !== (m_mode == 2) ||
          wrap !== m_wrap || seed_err !== m_err) begin
        errors++;
        $display("FAIL random cyc %0d: data=%0d busy=%b done=%b wrap=%b err=%b, want %0d %b %b %b %b",
                 c, data_out, busy, done, wrap, seed_err,
                 seq[m_idx], (m_mode == 1), (m_mode == 2), m_wrap, m_err);
      end
`ifdef LFSR_PERIOD_CNT_EN
      checks++;
      if (period_out !== 4'(m_per)) begin
        errors++;
        $display("FAIL random period cyc %0d: period=%0d, want %0d", c, period_out, m_per);
      end
`endif
    end
    rst = 1'b0; load = 1'b0; start = 1'b0; en = 1'b0;
  endtask

`ifdef LFSR_PERIOD_CNT_EN
  logic       rst8, en8;
  logic [7:0] data8, period8;
  logic       busy8, done8, wrap8, err8;

  lfsr_stepper #(.WIDTH(8), .TAPS(8'hB8), .SEED(8'h01), .CNT_W(16)) dut8 (
    .clk(clk), .rst(rst8), .en(en8), .load(1'b0), .seed_in(8'h00),
    .start(1'b0), .n_steps(16'h0000), .data_out(data8), .busy(busy8),
    .done(done8), .wrap(wrap8), .seed_err(err8), .period_out(period8)
  );

  task automatic test_period();
    int wraps;
    rst = 1'b1; tick(); rst = 1'b0;
    en = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    en = 1'b0;
    checks++;
    if (period_out !== 4'd15) begin
      errors++;
      $display("FAIL period4: period=%0d, want 15", period_out);
    end
    wraps = 0;
    rst8 = 1'b1; en8 = 1'b0;
    @(posedge clk); #1;
    rst8 = 1'b0; en8 = 1'b1;
    for (int i = 0; i < 255; i++) begin
      @(posedge clk); #1;
      if (wrap8 === 1'b1) wraps++;
    end
    en8 = 1'b0;
    checks++;
    if (wraps !== 1 || wrap8 !== 1'b1 || period8 !== 8'd255 || data8 !== 8'h01) begin
      errors++;
      $display("FAIL period8: wraps=%0d last_wrap=%b period=%0d data=%0h, want 1 1 255 01",
               wraps, wrap8, period8, data8);
    end
  endtask
`endif

  initial begin
`ifdef LFSR_PERIOD_CNT_EN
    rst8 = 1'b1; en8 = 1'b0;
`endif
    test_reset();
    test_free_run();
    test_counted();
    test_zero_steps();
    test_load_abort();
    test_en_during_run();
    test_random();
`ifdef LFSR_PERIOD_CNT_EN
    test_period();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
